// File: rtl/sensor_conditioner.sv
// Loop-detector conditioning ahead of the traffic light controller: per direction a
// synchroniser, debounce FSM, pending-request latch and stuck-high fault detector.
module sensor_channel #(
  parameter int DEBOUNCE     = 3,
  parameter int STUCK_CYCLES = 60,
  parameter int CW           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_i,
  input  logic [2:0] light_i,
  output logic       sensor_o,
  output logic       fault_o
);

  typedef enum logic [1:0] {IDLE, QUAL_ON, PRESENT, QUAL_OFF} deb_state_e;

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] STUCK_MAX = CW'(STUCK_CYCLES);

  deb_state_e    state_q, state_d;
  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] stuck_q, stuck_d;
  logic          presence_q, presence_d;
  logic          pending_q, pending_d;
  logic          fault_q, fault_d;
  logic          green;
  logic          entering_idle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      stuck_q    <= '0;
      presence_q <= 1'b0;
      pending_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      s1_q       <= raw_i;
      s2_q       <= s1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stuck_q    <= stuck_d;
      presence_q <= presence_d;
      pending_q  <= pending_d;
      fault_q    <= fault_d;
    end
  end

  // Debounce: any opposite sample during qualification abandons it with no credit kept.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    presence_d = presence_q;
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = QUAL_ON;
          cnt_d   = CW'(1);
        end
      end
      QUAL_ON: begin
        if (!s2_q) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d    = PRESENT;
          presence_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESENT: begin
        if (!s2_q) begin
          state_d = QUAL_OFF;
          cnt_d   = CW'(1);
        end
      end
      QUAL_OFF: begin
        if (s2_q) begin
          state_d = PRESENT;
        end else if (cnt_q == DEB_LAST) begin
          state_d    = IDLE;
          presence_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign green         = (light_i == 3'b001);
  assign entering_idle = (state_d == IDLE) && (state_q != IDLE);

  always_comb begin
    stuck_d   = '0;
    fault_d   = fault_q;
    pending_d = pending_q;
    if (!entering_idle && (state_q == PRESENT || state_q == QUAL_OFF)) begin
      stuck_d = (stuck_q == STUCK_MAX) ? stuck_q : stuck_q + CW'(1);
    end
    if (entering_idle) begin
      fault_d = 1'b0;
    end else if (stuck_d == STUCK_MAX) begin
      fault_d = 1'b1;
    end
    // Green clears regardless of a simultaneous presence rise; a faulty channel never requests.
    if (green || fault_q) begin
      pending_d = 1'b0;
    end else if (presence_d && !presence_q) begin
      pending_d = 1'b1;
    end
  end

  assign sensor_o = (presence_q | pending_q) & ~fault_q;
  assign fault_o  = fault_q;

endmodule

module sensor_conditioner #(
  parameter int DEBOUNCE     = 3,
  parameter int STUCK_CYCLES = 60,
  parameter int CW           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ns_raw,
  input  logic       ew_raw,
  input  logic [2:0] NS_light,
  input  logic [2:0] EW_light,
  output logic       NS_sensor,
  output logic       EW_sensor,
  output logic       ns_fault,
  output logic       ew_fault
);

  sensor_channel #(.DEBOUNCE(DEBOUNCE), .STUCK_CYCLES(STUCK_CYCLES), .CW(CW)) u_ns (
    .clk      (clk),
    .rst      (rst),
    .raw_i    (ns_raw),
    .light_i  (NS_light),
    .sensor_o (NS_sensor),
    .fault_o  (ns_fault)
  );

  sensor_channel #(.DEBOUNCE(DEBOUNCE), .STUCK_CYCLES(STUCK_CYCLES), .CW(CW)) u_ew (
    .clk      (clk),
    .rst      (rst),
    .raw_i    (ew_raw),
    .light_i  (EW_light),
    .sensor_o (EW_sensor),
    .fault_o  (ew_fault)
  );

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner; expected output vectors are
// {NS_sensor, EW_sensor, ns_fault, ew_fault} after each clock edge.
module tb_sensor_conditioner;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] GRN = 3'b001;

  logic       clk;
  logic       rst;
  logic       ns_raw, ew_raw;
  logic [2:0] NS_light, EW_light;
  logic       NS_sensor, EW_sensor, ns_fault, ew_fault;
  logic [3:0] dut_o;

  logic [3:0] exp_q[$];
  string      name_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  sensor_conditioner #(.DEBOUNCE(3), .STUCK_CYCLES(60), .CW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ns_raw    (ns_raw),
    .ew_raw    (ew_raw),
    .NS_light  (NS_light),
    .EW_light  (EW_light),
    .NS_sensor (NS_sensor),
    .EW_sensor (EW_sensor),
    .ns_fault  (ns_fault),
    .ew_fault  (ew_fault)
  );

  assign dut_o = {NS_sensor, EW_sensor, ns_fault, ew_fault};

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Driver tasks: inputs change on the falling edge, expectation is for the next rising edge.
  task automatic cyc(input string nm, input logic [3:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n, input string nm, input logic [3:0] e);
    repeat (n) cyc(nm, e);
  endtask

  // Scoreboard monitor
  initial begin
    logic [3:0] e;
    string      nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk(nm, dut_o, e);
      end
    end
  end

  initial begin
    rst      = 1'b0;
    ns_raw   = 1'b0;
    ew_raw   = 1'b0;
    NS_light = RED;
    EW_light = RED;
    repeat (2) @(negedge clk);
    chk("reset_hold", dut_o, 4'b0000);
    rst = 1'b1;
    run(3, "post_reset", 4'b0000);

    // NS press with red light: presence on 5th edge, then pending until green
    ns_raw = 1'b1;
    run(4, "ns_qual", 4'b0000);
    cyc("ns_present", 4'b1000);
    run(1, "ns_hold", 4'b1000);
    ns_raw = 1'b0;
    run(5, "ns_release_pending", 4'b1000);
    run(2, "ns_pending_hold", 4'b1000);
    NS_light = GRN;
    cyc("ns_green_clear", 4'b0000);
    NS_light = RED;
    run(2, "ns_cleared", 4'b0000);

    // EW 2-cycle glitch never qualifies
    ew_raw = 1'b1;
    run(2, "ew_glitch", 4'b0000);
    ew_raw = 1'b0;
    run(6, "ew_glitch_idle", 4'b0000);

    // EW pulse of exactly DEBOUNCE cycles qualifies
    ew_raw = 1'b1;
    run(3, "ew_min_qual", 4'b0000);
    ew_raw = 1'b0;
    cyc("ew_min_qual", 4'b0000);
    cyc("ew_min_present", 4'b0100);
    run(5, "ew_min_pending", 4'b0100);
    EW_light = GRN;
    cyc("ew_green_clear", 4'b0000);
    EW_light = RED;
    run(2, "ew_cleared", 4'b0000);

    // NS press during green: no pending; a 2-sample dropout keeps presence
    NS_light = GRN;
    ns_raw = 1'b1;
    run(4, "ns_grn_qual", 4'b0000);
    cyc("ns_grn_present", 4'b1000);
    run(2, "ns_grn_hold", 4'b1000);
    ns_raw = 1'b0;
    run(2, "ns_dropout", 4'b1000);
    ns_raw = 1'b1;
    run(6, "ns_dropout_recover", 4'b1000);
    ns_raw = 1'b0;
    run(4, "ns_grn_qual_off", 4'b1000);
    cyc("ns_grn_release", 4'b0000);
    NS_light = RED;
    run(2, "ns_grn_idle", 4'b0000);

    // Non-one-hot light counts as not green
    NS_light = 3'b011;
    ns_raw = 1'b1;
    run(4, "ns_bad_light_qual", 4'b0000);
    cyc("ns_bad_light_present", 4'b1000);
    ns_raw = 1'b0;
    run(5, "ns_bad_light_pending", 4'b1000);
    cyc("ns_bad_light_pending", 4'b1000);
    NS_light = GRN;
    cyc("ns_bad_light_clear", 4'b0000);
    NS_light = RED;
    run(2, "ns_bad_light_idle", 4'b0000);

    // EW stuck high: fault on 60th edge after presence, clears on return to IDLE
    ew_raw = 1'b1;
    run(4, "ew_stuck_qual", 4'b0000);
    cyc("ew_stuck_present", 4'b0100);
    run(59, "ew_stuck_count", 4'b0100);
    cyc("ew_fault_set", 4'b0001);
    run(3, "ew_fault_hold", 4'b0001);
    ew_raw = 1'b0;
    run(4, "ew_fault_qual_off", 4'b0001);
    cyc("ew_fault_clear", 4'b0000);
    run(2, "ew_after_fault", 4'b0000);
    ew_raw = 1'b1;
    run(4, "ew_repress_qual", 4'b0000);
    cyc("ew_repress_present", 4'b0100);
    ew_raw = 1'b0;
    run(5, "ew_repress_pending", 4'b0100);
    EW_light = GRN;
    cyc("ew_repress_clear", 4'b0000);
    EW_light = RED;
    run(2, "ew_repress_idle", 4'b0000);

    // Both channels pending and mid-qualification, then asynchronous reset
    ns_raw = 1'b1;
    ew_raw = 1'b1;
    run(4, "both_qual", 4'b0000);
    cyc("both_present", 4'b1100);
    ns_raw = 1'b0;
    ew_raw = 1'b0;
    run(5, "both_pending", 4'b1100);
    ns_raw = 1'b1;
    ew_raw = 1'b1;
    run(3, "both_requal", 4'b1100);
    rst = 1'b0;
    #1;
    chk("async_reset", dut_o, 4'b0000);
    run(2, "in_reset", 4'b0000);
    ns_raw = 1'b0;
    ew_raw = 1'b0;
    rst = 1'b1;
    cyc("reset_release", 4'b0000);
    ns_raw = 1'b1;
    ew_raw = 1'b1;
    run(2, "post_reset_glitch", 4'b0000);
    ns_raw = 1'b0;
    ew_raw = 1'b0;
    run(8, "post_reset_quiet", 4'b0000);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drained: got %0d entries left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
- Upstream of the traffic light controller; produces its NS_sensor/EW_sensor inputs from raw loop-detector lines.
- Per direction it does three things:
  - synchronises and debounces the raw line;
  - latches a pending request until that direction is served green;
  - masks a sensor that is stuck high.
- Consumes the controller's NS_light/EW_light outputs to clear requests.

Parameters:
- DEBOUNCE, 3: consecutive synchronised-high (or low) samples required to change presence; legal range 2..255.
- STUCK_CYCLES, 60: consecutive cycles of presence after which the channel is declared faulty; legal range DEBOUNCE+1..255.
- CW, 8: width of the per-channel debounce and stuck counters; must hold STUCK_CYCLES.

Ports:
- clk, input, 1: system clock; one cycle = one controller time unit.
- rst, input, 1: asynchronous, active-low reset.
- ns_raw, input, 1: raw North-South detector, asynchronous to clk.
- ew_raw, input, 1: raw East-West detector, asynchronous to clk.
- NS_light, input, 3: controller NS light, one-hot; red=100, yellow=010, green=001.
- EW_light, input, 3: controller EW light, same encoding.
- NS_sensor, output, 1: conditioned NS traffic request to the controller.
- EW_sensor, output, 1: conditioned EW traffic request to the controller.
- ns_fault, output, 1: NS stuck-high fault flag.
- ew_fault, output, 1: EW stuck-high fault flag.

Behaviour:
- Two identical, independent channels. The NS channel is described; EW is the same with its own signals.

Synchroniser:
- Two-flop synchroniser: raw -> s1 -> s2. Only s2 is used downstream.

Debounce FSM states: IDLE, QUAL_ON, PRESENT, QUAL_OFF. The counter is cnt[CW].
- IDLE, s2=1: go to QUAL_ON, cnt=1.
- QUAL_ON, s2=0: return to IDLE.
- QUAL_ON, s2=1 and cnt==DEBOUNCE-1: go to PRESENT, presence<=1.
- QUAL_ON, s2=1 otherwise: cnt++.
- PRESENT, s2=0: go to QUAL_OFF, cnt=1.
- QUAL_OFF, s2=1: return to PRESENT.
- QUAL_OFF, s2=0 and cnt==DEBOUNCE-1: go to IDLE, presence<=0.
- QUAL_OFF, s2=0 otherwise: cnt++.
- Latency: a clean raw rising edge asserts presence on the (DEBOUNCE+2)th clk edge after it. DEBOUNCE=3 gives 5 edges. Falling edge latency is the same.
- A pulse shorter than DEBOUNCE samples at s2 never asserts presence.

Pending latch:
- Sets on the edge where presence rises, provided the light is not green.
- Clears on any edge where the light samples exactly 3'b001.
- Clear wins over set.
- Any non-one-hot light value is treated as not green.

Stuck detector:
- stuck_cnt counts consecutive cycles in PRESENT or QUAL_OFF. It resets to 0 in IDLE and QUAL_ON and saturates at STUCK_CYCLES.
- fault sets on the edge where stuck_cnt reaches STUCK_CYCLES.
- While fault=1, pending is held at 0.
- fault clears on the edge the FSM enters IDLE.

Output:
- NS_sensor = (presence | pending) & ~fault.
- Decoded from registers only, so it is glitch-free.

Reset:
- Async, active-low; usable mid-operation.
- Clears s1, s2, cnt, stuck_cnt, presence, pending and fault; FSM goes to IDLE.
- All outputs are 0 while rst=0 and on the first edge after release.

Simultaneous events:
- The NS and EW channels never interact.
- Raw toggling during QUAL_ON or QUAL_OFF restarts qualification as defined by the transitions above; no partial credit is kept.

Test Plan:
1. Reset, then ns_raw=1 held with NS_light=red, DEBOUNCE=3 -> NS_sensor=1 exactly 5 edges after ns_raw rises; ew outputs stay 0.
2. ew_raw pulses high for 2 cycles, then low -> EW_sensor never asserts; FSM returns to IDLE.
3. ns_raw high 6 cycles, then low, with NS_light=red -> NS_sensor stays 1 after presence drops (pending). NS_light=001 for one cycle -> NS_sensor=0 on the next edge.
4. ns_raw rises while NS_light=green -> presence=1, pending stays 0. ns_raw falls -> NS_sensor=0 5 edges later.
5. ew_raw held high, STUCK_CYCLES=60 -> ew_fault=1 and EW_sensor=0 on the 60th edge after presence. ew_raw low -> ew_fault clears when the FSM reaches IDLE; a new clean press is accepted.
6. Assert rst=0 mid-QUAL_ON and with pending=1 on both channels -> all outputs 0 immediately (asynchronously). After release, a 2-cycle raw glitch produces no output.
